// File: rtl/enhanced_decryption_module_if.sv
// Word-level bus of the iterative decryptor: cipher/key request channel,
// plaintext response channel and a busy status flag.
interface enhanced_decryption_module_if #(
    parameter int N = 8
);
    // Both channels use valid/ready. A word moves on the rising edge where
    // valid && ready are both high. A producer holds valid and its payload
    // stable until that edge, and never waits on ready before raising valid.
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] cipher_in;
    logic [N-1:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] plain_out;
    logic         busy;

    modport master (
        output in_valid, cipher_in, key_in, out_ready,
        input  in_ready, out_valid, plain_out, busy
    );

    modport slave (
        input  in_valid, cipher_in, key_in, out_ready,
        output in_ready, out_valid, plain_out, busy
    );
endinterface

// File: rtl/enhanced_decryption_module.sv
// Iterative decryptor: one inverse round per clock (xor key^round, rotate
// right by one, inverse nibble S-box), rounds run ROUNDS-1 down to 0.
module enhanced_decryption_module #(
    parameter int N      = 8,
    parameter int ROUNDS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    enhanced_decryption_module_if.slave   bus,
    output logic [1:0]                    fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] INV [16] = '{
        4'd6, 4'd10, 4'd3, 4'd15, 4'd0, 4'd14, 4'd8, 4'd12,
        4'd5, 4'd2,  4'd1, 4'd9,  4'd11, 4'd4, 4'd7, 4'd13
    };

    state_t       state;
    state_t       state_next;
    logic [N-1:0] data_reg;
    logic [N-1:0] key_reg;
    logic [3:0]   rnd;
    logic         in_ready;
    logic         out_valid;
    logic         busy;

    function automatic logic [N-1:0] inv_round(
        input logic [N-1:0] x,
        input logic [N-1:0] k,
        input logic [3:0]   r
    );
        logic [N-1:0] y;
        y = x ^ (k ^ {{(N-4){1'b0}}, r});
        y = {y[0], y[N-1:1]};
        for (int i = 0; i < N/4; i++) begin
            y[4*i +: 4] = INV[y[4*i +: 4]];
        end
        return y;
    endfunction

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (rnd == 4'd0) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= '0;
            key_reg  <= '0;
            rnd      <= 4'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_reg <= bus.cipher_in;
                        key_reg  <= bus.key_in;
                        rnd      <= 4'(ROUNDS - 1);
                    end
                end
                RUN: begin
                    data_reg <= inv_round(data_reg, key_reg, rnd);
                    // rnd parks at 0 on the last round; DONE never looks at it
                    if (rnd != 4'd0) rnd <= rnd - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.plain_out = data_reg;
    assign fsm_state     = state;
endmodule

// File: tb/tb_enhanced_decryption_module.sv
// Bench for enhanced_decryption_module: directed scenarios plus a randomized
// round trip, checked every cycle against a transaction-level model.
module tb_enhanced_decryption_module;
    localparam int N      = 8;
    localparam int ROUNDS = 3;
    localparam logic [3:0] FWD [16] = '{
        4'd4, 4'd10, 4'd9, 4'd2, 4'd13, 4'd8, 4'd0, 4'd14,
        4'd6, 4'd11, 4'd1, 4'd12, 4'd7, 4'd15, 4'd5, 4'd3
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] fsm_state;

    enhanced_decryption_module_if #(.N(N)) bus ();

    enhanced_decryption_module #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] ref_enc(input logic [N-1:0] p, input logic [N-1:0] k);
        logic [N-1:0] x;
        x = p;
        for (int r = 0; r < ROUNDS; r++) begin
            for (int i = 0; i < N/4; i++) x[4*i +: 4] = FWD[x[4*i +: 4]];
            x = {x[N-2:0], x[N-1]};
            x = x ^ k ^ N'(r);
        end
        return x;
    endfunction

    function automatic logic [N-1:0] ref_dec(input logic [N-1:0] c, input logic [N-1:0] k);
        logic [N-1:0] x;
        logic [3:0]   nib;
        x = c;
        for (int r = ROUNDS - 1; r >= 0; r--) begin
            x = x ^ k ^ N'(r);
            x = {x[0], x[N-1:1]};
            for (int i = 0; i < N/4; i++) begin
                nib = x[4*i +: 4];
                for (int j = 0; j < 16; j++) begin
                    if (FWD[j] == nib) x[4*i +: 4] = 4'(j);
                end
            end
        end
        return x;
    endfunction

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [N-1:0] exp_q [$];
    logic [N-1:0] pt_q [$];
    bit model_on = 1'b0;
    bit pending  = 1'b0;
    bit rt_mode  = 1'b0;
    int acc_edge = 0;
    int n_out    = 0;

    // One word in flight at most; its result is due ROUNDS edges after the
    // edge that accepted it and stays up until the downstream takes it.
    always @(negedge clk) begin
        bit ov_exp;
        if (model_on) begin
            ov_exp = pending && (cyc >= acc_edge + ROUNDS);
            check("in_ready",  N'(bus.in_ready),  N'(!pending));
            check("out_valid", N'(bus.out_valid), N'(ov_exp));
            check("busy",      N'(bus.busy),      N'(pending));
            if (ov_exp && exp_q.size() > 0) check("plain_out", bus.plain_out, exp_q[0]);
            if (rst) begin
                pending = 1'b0;
                exp_q.delete();
                pt_q.delete();
            end else if (ov_exp && bus.out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (rt_mode && pt_q.size() > 0) check("round_trip", bus.plain_out, pt_q.pop_front());
                n_out++;
                pending = 1'b0;
            end else if (!pending && bus.in_valid) begin
                exp_q.push_back(ref_dec(bus.cipher_in, bus.key_in));
                pending  = 1'b1;
                acc_edge = cyc + 1;
            end
        end
        if (rst) model_on = 1'b1;
    end

    // ---------------- drivers ----------------
    // Presents a word and returns #1 after the edge that accepts it.
    task automatic send(input logic [N-1:0] c, input logic [N-1:0] k,
                        input logic [N-1:0] p, input bit track);
        int t;
        t = 0;
        bus.cipher_in = c;
        bus.key_in    = k;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        end else if (track) begin
            pt_q.push_back(p);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid_timeout actual=out_valid_low required=out_valid_high");
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((pending || exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", N'(pending), N'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        logic [N-1:0] p;
        logic [N-1:0] k;

        bus.in_valid  = 1'b0;
        bus.cipher_in = '0;
        bus.key_in    = '0;
        bus.out_ready = 1'b1;

        check("pin_dec_fc", ref_dec(8'hFC, 8'h00), 8'h00);
        check("pin_dec_d2", ref_dec(8'hD2, 8'hCC), 8'hAA);
        check("pin_enc_aa", ref_enc(8'hAA, 8'hCC), 8'hD2);
        check("pin_enc_00", ref_enc(8'h00, 8'h00), 8'hFC);

        do_reset(2);
        @(negedge clk);
        check("rst_in_ready",  N'(bus.in_ready),  N'(1));
        check("rst_out_valid", N'(bus.out_valid), N'(0));
        check("rst_busy",      N'(bus.busy),      N'(0));
        check("rst_plain_out", bus.plain_out,     8'h00);
        check("rst_state",     N'(fsm_state),     N'(0));

        // Basic word and latency.
        @(posedge clk); #1;
        send(8'hFC, 8'h00, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        wait_valid(n);
        check("latency_fc", N'(n), N'(ROUNDS + 1));
        check("plain_fc", bus.plain_out, 8'h00);
        @(negedge clk);
        check("in_ready_after_xfer", N'(bus.in_ready), N'(1));

        // Backpressure with an intruding request held during DONE.
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        send(8'hD2, 8'hCC, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        wait_valid(n);
        bus.cipher_in = 8'h5A;
        bus.key_in    = 8'h33;
        bus.in_valid  = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_plain_hold", bus.plain_out, 8'hAA);
        check("bp_in_ready",   N'(bus.in_ready), N'(0));
        base = n_out;
        bus.out_ready = 1'b1;
        send(8'h5A, 8'h33, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        wait_idle();
        check("bp_transfers", N'(n_out - base), N'(2));

        // Key changes while the word is running.
        @(posedge clk); #1;
        send(8'hD2, 8'hCC, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        bus.key_in   = 8'hFF;
        bus.cipher_in = 8'h00;
        wait_valid(n);
        check("key_change_plain", bus.plain_out, 8'hAA);
        wait_idle();

        // Reset on the second RUN cycle.
        @(posedge clk); #1;
        send(8'hFC, 8'h00, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", N'(bus.in_ready), N'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", N'(bus.out_valid), N'(0));
        check("post_rst_busy",      N'(bus.busy),      N'(0));
        check("post_rst_in_ready",  N'(bus.in_ready),  N'(1));
        @(posedge clk); #1;
        send(8'hFC, 8'h00, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        wait_valid(n);
        check("post_rst_plain", bus.plain_out, 8'h00);
        wait_idle();

        // Randomized round trip, back to back.
        rt_mode = 1'b1;
        base = n_out;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            p = N'($urandom_range(0, (1 << N) - 1));
            k = N'($urandom_range(0, (1 << N) - 1));
            send(ref_enc(p, k), k, p, 1'b1);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        check("rt_count", N'(n_out - base), N'(256));
        check("rt_leftover", N'(pt_q.size()), N'(0));
        rt_mode = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
